dac_frame_builder: RTL

- Upstream stage of the 24-bit DAC serializer.
- Accepts 12-bit audio samples with a channel tag over a valid/ready handshake and buffers them in a small FIFO.
- Formats each sample into the 24-bit DAC command word and presents it on a registered output.
- Advances to the next word exactly at the serializer's frame boundary, using the serializer's frame-end pulse.

---
 rtl/dac_frame_builder.sv | 104 ++++++++++
 1 files changed

// File: rtl/dac_frame_builder.sv
// Buffers tagged 12-bit samples and presents formatted 24-bit DAC command
// words. The output word advances only at the serializer's frame boundary.
module dac_frame_builder #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  CMD        = 4'b0011,
  parameter logic [11:0] IDLE_DATA  = 12'h800,
  parameter logic [3:0]  IDLE_CHAN  = 4'hF,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_chan,
  input  logic              frame_done,
  output logic [23:0]       dac_word,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  typedef enum logic [1:0] {StWait, StHi1, StHold} state_e;

  state_e                    state_q;
  logic [DATA_W+3:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic                      push;
  logic                      load;
  logic                      pop;
  logic                      fifo_empty;
  logic [DATA_W+3:0]         head;

  assign in_ready   = (fifo_level < LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign push       = in_valid && in_ready;
  // The second consecutive frame_done cycle is the wrap edge from bit 0 to bit 23.
  assign load       = (state_q == StHi1) && frame_done;
  assign pop        = load && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  // Sample storage; entries need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_chan, in_data};
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame FSM with registered word and underrun outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StWait;
      dac_word     <= {CMD, IDLE_CHAN, IDLE_DATA, 4'h0};
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (frame_done) state_q <= StHi1;
        end
        StHi1: begin
          if (frame_done) begin
            state_q <= StHold;
            if (!fifo_empty) begin
              dac_word <= {CMD, head[DATA_W+3:DATA_W], head[DATA_W-1:0], 4'h0};
            end else begin
              // Empty at the boundary: repeat the last word and flag it.
              underrun <= 1'b1;
              if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
            end
          end else begin
            state_q <= StWait;
          end
        end
        StHold: begin
          if (!frame_done) state_q <= StWait;
        end
        default: state_q <= StWait;
      endcase
    end
  end

endmodule
